bpu_btb: RTL and testbench

- Direct-mapped branch target buffer with 2-bit saturating direction counters. Next generation of the pipeline's PC-select logic.
- Parametrised depth and address width.
- Predicts taken branches at IF in the same cycle, so the fetch is not redirected late.
- Trained and checked at EX. Raises a mispredict redirect that replaces the old EX branch-taken flush.

---
 rtl/bpu_btb.sv | 164 ++++++++++++++++
 tb/tb_bpu_btb.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpu_btb.sv
// bpu_btb: direct-mapped branch target buffer with 2-bit saturating
// direction counters. Lookup at IF is combinational with no latency.
// Training and misprediction detection happen at EX.
// Optional statistics counters are built when BPU_BTB_STATS_EN is defined;
// without the macro the three stat ports read 0.
//
// EX handshake: ex_valid qualifies the ex_* bundle for exactly one cycle.
// Every cycle with ex_valid=1 at the clock edge is treated as a new
// instruction. The producer must drop ex_valid on stall or bubble cycles so
// that the same branch is not trained twice.
module bpu_btb #(
    parameter int         ENTRIES   = 16,
    parameter int         ADDR_W    = 32,
    parameter logic [1:0] CTR_ALLOC = 2'b10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush_all,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_next_pc,
    input  logic              ex_valid,
    input  logic              ex_is_branch,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic              ex_taken,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              ex_pred_taken,
    input  logic [ADDR_W-1:0] ex_pred_target,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       stat_lookups,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    // Table storage
    logic              r_valid  [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic [ADDR_W-1:0] r_target [ENTRIES];
    logic [1:0]        r_ctr    [ENTRIES];

    // IF-side lookup signals
    logic [IDX_W-1:0]  w_if_idx;
    logic [TAG_W-1:0]  w_if_tag;
    logic              w_hit;
    logic [ADDR_W-1:0] w_if_pc_inc;

    // EX-side training signals
    logic [IDX_W-1:0]  w_ex_idx;
    logic [TAG_W-1:0]  w_ex_tag;
    logic              w_ex_tag_hit;
    logic              w_br_upd;
    logic              w_alias;
    logic              w_br_mis;
    logic [ADDR_W-1:0] w_ex_pc_inc;

    assign w_if_idx    = if_pc[IDX_W+1:2];
    assign w_if_tag    = if_pc[ADDR_W-1:IDX_W+2];
    assign w_if_pc_inc = if_pc + ADDR_W'(4);

    assign w_ex_idx    = ex_pc[IDX_W+1:2];
    assign w_ex_tag    = ex_pc[ADDR_W-1:IDX_W+2];
    assign w_ex_pc_inc = ex_pc + ADDR_W'(4);

    // Lookup reads the stored contents directly; an update on the same
    // edge is not bypassed, so IF always sees the pre-update entry.
    always_comb begin
        w_hit        = reset_n & if_valid & r_valid[w_if_idx] &
                       (r_tag[w_if_idx] == w_if_tag);
        pred_taken   = w_hit & r_ctr[w_if_idx][1];
        pred_next_pc = pred_taken ? r_target[w_if_idx] : w_if_pc_inc;
    end

    // EX classification: a resolved branch, or a non-branch that was
    // predicted taken because a different PC aliased into its slot.
    always_comb begin
        w_ex_tag_hit = r_valid[w_ex_idx] & (r_tag[w_ex_idx] == w_ex_tag);
        w_br_upd     = ex_valid & ex_is_branch;
        w_alias      = ex_valid & ~ex_is_branch & ex_pred_taken;
        w_br_mis     = w_br_upd &
                       ((ex_taken != ex_pred_taken) |
                        (ex_taken & (ex_target != ex_pred_target)));
    end

    // Redirect generation; both outputs are held inactive during reset.
    always_comb begin
        mispredict  = reset_n & (w_br_mis | w_alias);
        redirect_pc = '0;
        if (reset_n) begin
            if (w_alias || !ex_taken) begin
                redirect_pc = w_ex_pc_inc;
            end else begin
                redirect_pc = ex_target;
            end
        end
    end

    // Table update: reset clears everything, flush_all drops all valid bits
    // and overrides any same-cycle training, otherwise train from EX.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b00;
            end
        end else if (flush_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else if (w_br_upd) begin
            if (w_ex_tag_hit) begin
                if (ex_taken) begin
                    r_ctr[w_ex_idx]    <= (r_ctr[w_ex_idx] == 2'b11) ? 2'b11
                                          : r_ctr[w_ex_idx] + 2'b01;
                    r_target[w_ex_idx] <= ex_target;
                end else begin
                    r_ctr[w_ex_idx]    <= (r_ctr[w_ex_idx] == 2'b00) ? 2'b00
                                          : r_ctr[w_ex_idx] - 2'b01;
                end
            end else if (ex_taken) begin
                r_valid[w_ex_idx]  <= 1'b1;
                r_tag[w_ex_idx]    <= w_ex_tag;
                r_target[w_ex_idx] <= ex_target;
                r_ctr[w_ex_idx]    <= CTR_ALLOC;
            end
        end else if (w_alias && w_ex_tag_hit) begin
            r_valid[w_ex_idx] <= 1'b0;
        end
    end

`ifdef BPU_BTB_STATS_EN
    logic [31:0] r_stat_lookups;
    logic [31:0] r_stat_hits;
    logic [31:0] r_stat_mispredicts;

    // Wrapping event counters; cleared by reset only, unaffected by flush.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stat_lookups     <= '0;
            r_stat_hits        <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (if_valid)   r_stat_lookups     <= r_stat_lookups + 32'd1;
            if (w_hit)      r_stat_hits        <= r_stat_hits + 32'd1;
            if (mispredict) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
        end
    end

    assign stat_lookups     = r_stat_lookups;
    assign stat_hits        = r_stat_hits;
    assign stat_mispredicts = r_stat_mispredicts;
`else
    assign stat_lookups     = 32'd0;
    assign stat_hits        = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_bpu_btb.sv
// Directed testbench for bpu_btb (ENTRIES=16, ADDR_W=32).
// Inputs change 1 time unit after a rising edge; outputs are checked
// 1 unit later, well away from the next edge.
module tb_bpu_btb;

  logic        clk;
  logic        reset_n;
  logic        flush_all;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] stat_lookups;
  logic [31:0] stat_hits;
  logic [31:0] stat_mispredicts;

  int n_checks = 0;
  int n_fail   = 0;

  bpu_btb #(.ENTRIES(16), .ADDR_W(32), .CTR_ALLOC(2'b10)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .flush_all        (flush_all),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .pred_next_pc     (pred_next_pc),
    .ex_valid         (ex_valid),
    .ex_is_branch     (ex_is_branch),
    .ex_pc            (ex_pc),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .stat_lookups     (stat_lookups),
    .stat_hits        (stat_hits),
    .stat_mispredicts (stat_mispredicts)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic ex_idle();
    ex_valid       = 1'b0;
    ex_is_branch   = 1'b0;
    ex_pc          = 32'h0;
    ex_taken       = 1'b0;
    ex_target      = 32'h0;
    ex_pred_taken  = 1'b0;
    ex_pred_target = 32'h0;
  endtask

  task automatic ex_branch(input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt, input logic ptk,
                           input logic [31:0] ptgt);
    ex_valid       = 1'b1;
    ex_is_branch   = 1'b1;
    ex_pc          = pc;
    ex_taken       = tk;
    ex_target      = tgt;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
  endtask

  task automatic ex_nonbranch(input logic [31:0] pc, input logic ptk,
                              input logic [31:0] ptgt);
    ex_valid       = 1'b1;
    ex_is_branch   = 1'b0;
    ex_pc          = pc;
    ex_taken       = 1'b0;
    ex_target      = 32'h0;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
  endtask

  task automatic lookup(input logic [31:0] pc);
    if_valid = 1'b1;
    if_pc    = pc;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_pred(input string tag, input logic tk,
                            input logic [31:0] npc);
    check({tag, ".pred_taken"}, {31'd0, pred_taken}, {31'd0, tk});
    check({tag, ".pred_next_pc"}, pred_next_pc, npc);
  endtask

  task automatic check_mis(input string tag, input logic mis,
                           input logic [31:0] rpc);
    check({tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, mis});
    if (mis) check({tag, ".redirect_pc"}, redirect_pc, rpc);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n   = 1'b0;
    flush_all = 1'b0;
    if_valid  = 1'b0;
    if_pc     = 32'h0;
    ex_idle();

    // Reset: outputs forced, even with a would-be mispredict on EX
    #1;
    lookup(32'h40);
    ex_branch(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    settle();
    check_pred("rst", 1'b0, 32'h44);
    check("rst.mispredict", {31'd0, mispredict}, 32'd0);
    check("rst.redirect_pc", redirect_pc, 32'h0);
    step();
    step();
    check_pred("rst2", 1'b0, 32'h44);

    // Out of reset: empty table
    reset_n = 1'b1;
    ex_idle();
    settle();
    check_pred("empty", 1'b0, 32'h44);
    check_mis("empty", 1'b0, 32'h0);
    check("empty.stat_lookups", stat_lookups, 32'd0);

    // Allocate 0x40 -> 0x100; same-cycle lookup sees old contents
    ex_branch(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    settle();
    check_mis("alloc", 1'b1, 32'h100);
    check_pred("alloc.nobypass", 1'b0, 32'h44);
    step();
    ex_idle();
    settle();
    check_pred("alloc.after", 1'b1, 32'h100);            // ctr 10

    // Taken twice more, correctly predicted: 10->11->11
    ex_branch(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    settle();
    check_mis("t1", 1'b0, 32'h0);
    step();
    check_pred("t1.after", 1'b1, 32'h100);               // 11
    settle();
    check_mis("t2", 1'b0, 32'h0);
    step();
    check_pred("t2.after", 1'b1, 32'h100);               // 11 saturated

    // Not taken four times: 11->10->01->00->00
    ex_branch(32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
    settle();
    check_mis("n1", 1'b1, 32'h44);
    step();
    check_pred("n1.after", 1'b1, 32'h100);               // 10
    settle();
    check_mis("n2", 1'b1, 32'h44);
    step();
    check_pred("n2.after", 1'b0, 32'h44);                // 01
    ex_branch(32'h40, 1'b0, 32'h100, 1'b0, 32'h44);
    settle();
    check_mis("n3", 1'b0, 32'h0);
    step();
    check_pred("n3.after", 1'b0, 32'h44);                // 00
    step();
    check_pred("n4.after", 1'b0, 32'h44);                // 00 saturated

    // Walk back up: 00->01->10
    ex_branch(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    settle();
    check_mis("u1", 1'b1, 32'h100);
    step();
    check_pred("u1.after", 1'b0, 32'h44);                // 01
    step();
    check_pred("u2.after", 1'b1, 32'h100);               // 10

    // Right direction, wrong target: mispredict and retarget to 0x200
    ex_branch(32'h40, 1'b1, 32'h200, 1'b1, 32'h100);
    settle();
    check_mis("tgt", 1'b1, 32'h200);
    step();
    ex_idle();
    settle();
    check_pred("tgt.after", 1'b1, 32'h200);              // 11

    // Aliasing non-branch at 0x80 (idx 0, other tag): entry kept
    lookup(32'h80);
    ex_nonbranch(32'h80, 1'b1, 32'h200);
    settle();
    check_pred("alias.lookup80", 1'b0, 32'h84);
    check_mis("alias", 1'b1, 32'h84);
    step();
    ex_idle();
    lookup(32'h40);
    settle();
    check_pred("alias.kept", 1'b1, 32'h200);

    // Non-branch not predicted taken: nothing happens
    ex_nonbranch(32'h40, 1'b0, 32'h0);
    settle();
    check_mis("nonbr.quiet", 1'b0, 32'h0);
    step();
    check_pred("nonbr.quiet.after", 1'b1, 32'h200);

    // Tag-matching non-branch predicted taken: entry invalidated
    ex_nonbranch(32'h40, 1'b1, 32'h200);
    settle();
    check_mis("alias.match", 1'b1, 32'h44);
    step();
    ex_idle();
    settle();
    check_pred("alias.match.after", 1'b0, 32'h44);

    // Not-taken miss allocates nothing; ex_valid=0 trains nothing
    ex_branch(32'h48, 1'b0, 32'h300, 1'b0, 32'h0);
    step();
    ex_branch(32'h4c, 1'b1, 32'h300, 1'b0, 32'h0);
    ex_valid = 1'b0;
    settle();
    check_mis("bubble", 1'b0, 32'h0);
    step();
    ex_idle();
    lookup(32'h48);
    settle();
    check_pred("nt.miss", 1'b0, 32'h4c);
    lookup(32'h4c);
    settle();
    check_pred("bubble.after", 1'b0, 32'h50);

    // Allocate 0x48, then allocate 0x40 together with flush_all
    ex_branch(32'h48, 1'b1, 32'h300, 1'b0, 32'h0);
    step();
    ex_idle();
    lookup(32'h48);
    settle();
    check_pred("pre.flush", 1'b1, 32'h300);
    ex_branch(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    flush_all = 1'b1;
    step();
    flush_all = 1'b0;
    ex_idle();
    lookup(32'h40);
    settle();
    check_pred("flush.40", 1'b0, 32'h44);
    lookup(32'h48);
    settle();
    check_pred("flush.48", 1'b0, 32'h4c);

    // PC increment wraps modulo 2^32
    lookup(32'hFFFF_FFFC);
    settle();
    check_pred("wrap", 1'b0, 32'h0);

    // Reset mid-operation discards training
    ex_branch(32'h50, 1'b1, 32'h500, 1'b0, 32'h0);
    step();
    ex_idle();
    lookup(32'h50);
    settle();
    check_pred("pre.reset", 1'b1, 32'h500);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    settle();
    check_pred("post.reset", 1'b0, 32'h54);

    // Statistics: fresh reset, 1 mispredict, 10 lookups (3 hits), 1 more
    if_valid = 1'b0;
    reset_n  = 1'b0;
    step();
    reset_n = 1'b1;
    ex_branch(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    step();
    ex_idle();
    for (int i = 0; i < 10; i++) begin
      lookup((i < 3) ? 32'h40 : 32'h60);
      step();
    end
    if_valid = 1'b0;
    ex_nonbranch(32'h80, 1'b1, 32'h100);
    step();
    ex_idle();
    settle();
`ifdef BPU_BTB_STATS_EN
    check("stat.lookups", stat_lookups, 32'd10);
    check("stat.hits", stat_hits, 32'd3);
    check("stat.mispredicts", stat_mispredicts, 32'd2);
`else
    check("stat.lookups", stat_lookups, 32'd0);
    check("stat.hits", stat_hits, 32'd0);
    check("stat.mispredicts", stat_mispredicts, 32'd0);
`endif

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
